des_out_buffer: RTL and testbench



---
 rtl/des_pkg.sv | 9 +
 rtl/des_fifo_mem.sv | 33 +++
 rtl/des_out_buffer.sv | 70 +++++++
 tb/tb_des_out_buffer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// des_pkg: shared widths and depth limits for the DES result path.
package des_pkg;
   localparam int DES_BLK_W = 64;
   localparam int DES_PIPE_LAT = 16;
   localparam int DES_MIN_BUF_DEPTH = DES_PIPE_LAT + 1;
   function automatic bit depth_ok(int d);
      return d >= DES_MIN_BUF_DEPTH && (d & (d - 1)) == 0;
   endfunction
endpackage

// File: rtl/des_fifo_mem.sv
// des_fifo_mem: DEPTH x 64 register-array FIFO with first-word-fall-through read.
module des_fifo_mem
   import des_pkg::*;
#(
   parameter int DEPTH = 32,
   parameter int AW = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 push,
   input  logic                 pop,
   input  logic [DES_BLK_W-1:0] wdata,
   output logic [DES_BLK_W-1:0] rdata,
   output logic [AW:0]          count
);
   logic [DES_BLK_W-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= wdata;
   // pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
      end else begin
         wr_ptr <= wr_ptr + AW'(push);
         rd_ptr <= rd_ptr + AW'(pop);
         count <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
   // empty reads as zero so the output word is defined out of reset
   assign rdata = count != '0 ? mem[rd_ptr] : '0;
endmodule

// File: rtl/des_out_buffer.sv
// des_out_buffer: captures DES core results into a FIFO, streams them out and
// returns issue credits so the non-stallable core never overruns the buffer.
module des_out_buffer
   import des_pkg::*;
#(
   parameter int DEPTH = 32,
   parameter int AW = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 issue_en,
   output logic                 issue_ready,
   input  logic                 core_valid,
   input  logic [DES_BLK_W-1:0] core_data,
   output logic                 m_valid,
   output logic [DES_BLK_W-1:0] m_data,
   input  logic                 m_ready,
   input  logic                 err_clr,
   output logic                 err_credit,
   output logic                 err_drop,
   output logic                 err_spurious,
   output logic [31:0]          blk_cnt
);
   if (!depth_ok(DEPTH) || (1 << AW) != DEPTH) begin : g_bad_depth
      $error("des_out_buffer: DEPTH must be a power of two >= %0d with AW = log2(DEPTH)", DES_MIN_BUF_DEPTH);
   end
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
   logic [AW:0] credits, inflight, count, credits_next, inflight_add, inflight_next;
   logic accept, push, pop, full, no_credit, drop, spurious;
   always_comb begin
      pop = m_valid && m_ready;
      full = count == FULL;
      no_credit = credits == '0;
      accept = issue_en && !no_credit;
      push = core_valid && (!full || pop);
      drop = core_valid && full && !pop;
      spurious = core_valid && inflight == '0;
      credits_next = credits - (AW+1)'(accept) + (AW+1)'(pop);
      inflight_add = inflight + (AW+1)'(accept);
      inflight_next = inflight_add - (AW+1)'(core_valid && inflight_add != '0);
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         credits <= FULL;
         inflight <= '0;
         issue_ready <= 1'b1;
         err_credit <= 1'b0;
         err_drop <= 1'b0;
         err_spurious <= 1'b0;
         blk_cnt <= '0;
      end else begin
         credits <= credits_next;
         inflight <= inflight_next;
         issue_ready <= credits_next != '0;
         err_credit <= (issue_en && no_credit) || (err_credit && !err_clr);
         err_drop <= drop || (err_drop && !err_clr);
         err_spurious <= spurious || (err_spurious && !err_clr);
         blk_cnt <= blk_cnt + 32'(pop);
      end
   assign m_valid = count != '0;
   des_fifo_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
      .clk(clk),
      .rst(rst),
      .push(push),
      .pop(pop),
      .wdata(core_data),
      .rdata(m_data),
      .count(count)
   );
endmodule

// File: tb/tb_des_out_buffer.sv
// tb_des_out_buffer: directed and randomized checks against a queue-based model.
module tb_des_out_buffer;
   localparam int DEPTH = 32;
   logic clk = 0, rst = 0, issue_en = 0, core_valid = 0, m_ready = 0, err_clr = 0;
   logic [63:0] core_data = '0;
   logic issue_ready, m_valid, err_credit, err_drop, err_spurious;
   logic [63:0] m_data;
   logic [31:0] blk_cnt;
   int checks = 0, errors = 0;
   logic [63:0] q[$];
   int cred = DEPTH, fly = 0;
   logic e_cr = 0, e_dr = 0, e_sp = 0;
   logic [31:0] blk = 0;
   logic core_auto = 0;
   logic pv[16];
   logic [63:0] pd[16];

   des_out_buffer #(.DEPTH(DEPTH), .AW(5)) dut (
      .clk(clk), .rst(rst), .issue_en(issue_en), .issue_ready(issue_ready),
      .core_valid(core_valid), .core_data(core_data), .m_valid(m_valid), .m_data(m_data),
      .m_ready(m_ready), .err_clr(err_clr), .err_credit(err_credit), .err_drop(err_drop),
      .err_spurious(err_spurious), .blk_cnt(blk_cnt)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      q.delete();
      cred = DEPTH;
      fly = 0;
      e_cr = 0;
      e_dr = 0;
      e_sp = 0;
      blk = 0;
      for (int i = 0; i < 16; i++) begin
         pv[i] = 0;
         pd[i] = '0;
      end
   endtask

   // advance one clock: update the model from the inputs presented this cycle,
   // then (optionally) run the 16-deep core delay line
   task automatic tick();
      bit mv, pop, acc, push, ecr, edr, esp;
      mv = q.size() != 0;
      pop = mv && m_ready;
      acc = issue_en && cred > 0;
      push = core_valid && (q.size() < DEPTH || pop);
      ecr = issue_en && cred == 0;
      edr = core_valid && q.size() == DEPTH && !pop;
      esp = core_valid && fly == 0;
      if (pop) void'(q.pop_front());
      if (push) q.push_back(core_data);
      cred = cred - int'(acc) + int'(pop);
      fly = fly + int'(acc) - int'(core_valid);
      if (fly < 0) fly = 0;
      e_cr = ecr | (e_cr & !err_clr);
      e_dr = edr | (e_dr & !err_clr);
      e_sp = esp | (e_sp & !err_clr);
      blk = blk + 32'(pop);
      @(posedge clk);
      #1;
      if (core_auto) begin
         for (int i = 15; i > 0; i--) begin
            pv[i] = pv[i-1];
            pd[i] = pd[i-1];
         end
         pv[0] = issue_en;
         pd[0] = {$urandom, $urandom};
         core_valid = pv[15];
         core_data = pd[15];
      end
   endtask

   task automatic do_reset();
      issue_en = 0;
      core_valid = 0;
      m_ready = 0;
      err_clr = 0;
      core_auto = 0;
      @(posedge clk);
      #1;
      rst = 1;
      #2;
      rst = 0;
      model_reset();
   endtask

   task automatic test_reset();
      @(posedge clk);
      #1;
      rst = 1;
      #1;
      checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got %b exp 0", m_valid); end
      checks++; if (m_data !== 64'h0) begin errors++; $display("FAIL reset_m_data got %h exp 0", m_data); end
      checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL reset_issue_ready got %b exp 1", issue_ready); end
      checks++; if (dut.credits !== 6'd32) begin errors++; $display("FAIL reset_credits got %0d exp 32", dut.credits); end
      checks++; if ({err_credit, err_drop, err_spurious} !== 3'b000) begin errors++; $display("FAIL reset_errs got %b exp 000", {err_credit, err_drop, err_spurious}); end
      checks++; if (blk_cnt !== 32'd0) begin errors++; $display("FAIL reset_blk_cnt got %0d exp 0", blk_cnt); end
      @(posedge clk);
      #1;
      rst = 0;
      model_reset();
   endtask

   task automatic test_single();
      m_ready = 1;
      issue_en = 1;
      tick();
      issue_en = 0;
      repeat (15) tick();
      core_valid = 1;
      core_data = 64'h85E813540F0AB405;
      tick();
      core_valid = 0;
      checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL single_valid_c17 got %b exp 1", m_valid); end
      checks++; if (m_data !== 64'h85E813540F0AB405) begin errors++; $display("FAIL single_data got %h exp 85e813540f0ab405", m_data); end
      tick();
      checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL single_valid_c18 got %b exp 0", m_valid); end
      checks++; if (blk_cnt !== 32'd1) begin errors++; $display("FAIL single_blk_cnt got %0d exp 1", blk_cnt); end
      checks++; if (dut.credits !== 6'd32) begin errors++; $display("FAIL single_credits got %0d exp 32", dut.credits); end
      checks++; if (err_spurious !== 1'b0) begin errors++; $display("FAIL single_spurious got %b exp 0", err_spurious); end
   endtask

   task automatic test_backpressure();
      int accepts = 0;
      m_ready = 0;
      core_auto = 1;
      for (int c = 0; c < 50; c++) begin
         issue_en = issue_ready;
         if (issue_en && issue_ready) accepts++;
         tick();
         checks++; if (issue_ready !== (cred != 0)) begin errors++; $display("FAIL bp_ready c%0d got %b exp %b", c, issue_ready, cred != 0); end
         checks++; if (m_valid !== (q.size() != 0)) begin errors++; $display("FAIL bp_valid c%0d got %b exp %b", c, m_valid, q.size() != 0); end
      end
      issue_en = 0;
      checks++; if (accepts != 32) begin errors++; $display("FAIL bp_accepts got %0d exp 32", accepts); end
      checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_low got %b exp 0", issue_ready); end
      checks++; if (dut.u_mem.count !== 6'd32) begin errors++; $display("FAIL bp_count got %0d exp 32", dut.u_mem.count); end
      checks++; if (err_drop !== 1'b0) begin errors++; $display("FAIL bp_err_drop got %b exp 0", err_drop); end
      m_ready = 1;
      tick();
      m_ready = 0;
      checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after_pop got %b exp 1", issue_ready); end
      m_ready = 1;
      for (int c = 0; c < 33; c++) begin
         checks++; if (q.size() != 0 && m_data !== q[0]) begin errors++; $display("FAIL bp_drain_data c%0d got %h exp %h", c, m_data, q[0]); end
         tick();
      end
      checks++; if (m_valid !== 1'b0 || blk_cnt !== blk) begin errors++; $display("FAIL bp_drained got valid=%b blk=%0d exp valid=0 blk=%0d", m_valid, blk_cnt, blk); end
      core_auto = 0;
   endtask

   task automatic test_push_pop();
      logic [63:0] a = 64'h0123456789ABCDEF, b = 64'hFEDCBA9876543210;
      m_ready = 1;
      issue_en = 1;
      repeat (2) tick();
      issue_en = 0;
      repeat (14) tick();
      core_valid = 1;
      core_data = a;
      tick();
      core_data = b;
      checks++; if (m_valid !== 1'b1 || m_data !== a) begin errors++; $display("FAIL pp_first got %b/%h exp 1/%h", m_valid, m_data, a); end
      tick();
      core_valid = 0;
      checks++; if (dut.u_mem.count !== 6'd1) begin errors++; $display("FAIL pp_count got %0d exp 1", dut.u_mem.count); end
      checks++; if (m_valid !== 1'b1 || m_data !== b) begin errors++; $display("FAIL pp_second got %b/%h exp 1/%h", m_valid, m_data, b); end
      tick();
      checks++; if (m_valid !== 1'b0 || err_spurious !== 1'b0) begin errors++; $display("FAIL pp_end got valid=%b spur=%b exp 0/0", m_valid, err_spurious); end
   endtask

   task automatic test_errors();
      logic [63:0] last = 64'hA5A5_5A5A_DEAD_BEEF;
      m_ready = 0;
      core_valid = 1;
      core_data = {$urandom, $urandom};
      tick();
      core_valid = 0;
      checks++; if (err_spurious !== 1'b1) begin errors++; $display("FAIL err_spurious got %b exp 1", err_spurious); end
      checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL err_spurious_pushed got %b exp 1", m_valid); end
      issue_en = 1;
      repeat (40) tick();
      issue_en = 0;
      checks++; if (err_credit !== 1'b1) begin errors++; $display("FAIL err_credit got %b exp 1", err_credit); end
      checks++; if (dut.credits !== 6'd0) begin errors++; $display("FAIL err_credits_zero got %0d exp 0", dut.credits); end
      checks++; if (dut.inflight !== 6'(fly)) begin errors++; $display("FAIL err_inflight got %0d exp %0d", dut.inflight, fly); end
      err_clr = 1;
      tick();
      err_clr = 0;
      checks++; if ({err_credit, err_spurious} !== 2'b00) begin errors++; $display("FAIL err_clr got %b exp 00", {err_credit, err_spurious}); end
      err_clr = 1;
      issue_en = 1;
      tick();
      err_clr = 0;
      issue_en = 0;
      checks++; if (err_credit !== 1'b1) begin errors++; $display("FAIL err_set_wins got %b exp 1", err_credit); end
      core_valid = 1;
      for (int c = 0; c < 32; c++) begin
         core_data = {$urandom, $urandom};
         tick();
      end
      checks++; if (err_drop !== e_dr || err_drop !== 1'b1) begin errors++; $display("FAIL err_drop got %b exp 1", err_drop); end
      checks++; if (dut.u_mem.count !== 6'd32) begin errors++; $display("FAIL err_full_count got %0d exp 32", dut.u_mem.count); end
      core_data = last;
      m_ready = 1;
      tick();
      core_valid = 0;
      checks++; if (dut.u_mem.count !== 6'd32) begin errors++; $display("FAIL full_pop_push_count got %0d exp 32", dut.u_mem.count); end
      for (int c = 0; c < 32; c++) begin
         checks++; if (m_valid !== 1'b1 || m_data !== q[0]) begin errors++; $display("FAIL err_drain c%0d got %b/%h exp 1/%h", c, m_valid, m_data, q[0]); end
         tick();
      end
      checks++; if (q.size() != 0 || blk_cnt !== blk) begin errors++; $display("FAIL err_drain_end got blk=%0d exp %0d qsize=%0d", blk_cnt, blk, q.size()); end
      do_reset();
   endtask

   task automatic test_reset_mid();
      core_auto = 1;
      m_ready = 0;
      issue_en = 1;
      repeat (8) tick();
      issue_en = 0;
      repeat (13) tick();
      checks++; if (dut.u_mem.count !== 6'(q.size()) || q.size() != 5) begin errors++; $display("FAIL mid_count got %0d exp %0d", dut.u_mem.count, q.size()); end
      checks++; if (dut.inflight !== 6'(fly) || fly != 3) begin errors++; $display("FAIL mid_inflight got %0d exp %0d", dut.inflight, fly); end
      #1;
      rst = 1;
      #1;
      checks++; if (dut.credits !== 6'd32 || m_valid !== 1'b0) begin errors++; $display("FAIL mid_reset got credits=%0d valid=%b exp 32/0", dut.credits, m_valid); end
      checks++; if (dut.inflight !== 6'd0 || dut.u_mem.count !== 6'd0) begin errors++; $display("FAIL mid_reset_state got inflight=%0d count=%0d exp 0/0", dut.inflight, dut.u_mem.count); end
      do_reset();
   endtask

   task automatic test_random();
      model_reset();
      core_auto = 1;
      for (int c = 0; c < 3000; c++) begin
         issue_en = issue_ready && ($urandom_range(0, 3) != 0);
         m_ready = c % 600 < 300 ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 8);
         tick();
         checks++; if (m_valid !== (q.size() != 0)) begin errors++; $display("FAIL rnd_valid c%0d got %b exp %b", c, m_valid, q.size() != 0); end
         if (q.size() != 0) begin
            checks++; if (m_data !== q[0]) begin errors++; $display("FAIL rnd_data c%0d got %h exp %h", c, m_data, q[0]); end
         end
         checks++; if (issue_ready !== (cred != 0)) begin errors++; $display("FAIL rnd_ready c%0d got %b exp %b", c, issue_ready, cred != 0); end
         checks++; if (blk_cnt !== blk) begin errors++; $display("FAIL rnd_blk c%0d got %0d exp %0d", c, blk_cnt, blk); end
         checks++; if ({err_credit, err_drop, err_spurious} !== {e_cr, e_dr, e_sp} || e_dr) begin errors++; $display("FAIL rnd_errs c%0d got %b exp %b", c, {err_credit, err_drop, err_spurious}, {e_cr, e_dr, e_sp}); end
         checks++; if (cred + fly + q.size() != DEPTH) begin errors++; $display("FAIL rnd_invariant c%0d got %0d exp %0d", c, cred + fly + q.size(), DEPTH); end
      end
      issue_en = 0;
      core_auto = 0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_backpressure();
      test_push_pop();
      test_errors();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
